// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU op codes, op classes and the
// decoded-entry bundle carried through the decode stage.
package decode_pkg;

    localparam int DEC_XLEN    = 32;
    localparam int DEC_ALUOP_W = 8;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [DEC_ALUOP_W-1:0] ALU_NOP   = 8'h00;
    localparam logic [DEC_ALUOP_W-1:0] ALU_ADD   = 8'h01;
    localparam logic [DEC_ALUOP_W-1:0] ALU_SUB   = 8'h02;
    localparam logic [DEC_ALUOP_W-1:0] ALU_SLL   = 8'h03;
    localparam logic [DEC_ALUOP_W-1:0] ALU_SLT   = 8'h04;
    localparam logic [DEC_ALUOP_W-1:0] ALU_SLTU  = 8'h05;
    localparam logic [DEC_ALUOP_W-1:0] ALU_XOR   = 8'h06;
    localparam logic [DEC_ALUOP_W-1:0] ALU_SRL   = 8'h07;
    localparam logic [DEC_ALUOP_W-1:0] ALU_SRA   = 8'h08;
    localparam logic [DEC_ALUOP_W-1:0] ALU_OR    = 8'h09;
    localparam logic [DEC_ALUOP_W-1:0] ALU_AND   = 8'h0a;
    localparam logic [DEC_ALUOP_W-1:0] ALU_PASSB = 8'h0b;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JAL    = 3'd4,
        CLS_JALR   = 3'd5,
        CLS_LUI    = 3'd6,
        CLS_AUIPC  = 3'd7
    } op_class_e;

    typedef struct packed {
        logic [4:0]              rs1_addr;
        logic [4:0]              rs2_addr;
        logic [4:0]              w_addr;
        logic [DEC_XLEN-1:0]     imm;
        logic [DEC_ALUOP_W-1:0]  aluop;
        op_class_e               op_class;
        logic [2:0]              funct3;
        logic                    r1_enable;
        logic                    r2_enable;
        logic                    w_enable;
        logic                    imm_enable;
        logic                    illegal;
    } decoded_t;

    // funct3 -> ALU op for the non-alternate (funct7[5]=0) R/I arithmetic group
    function automatic logic [DEC_ALUOP_W-1:0] alu_base(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_decode_comb.sv
// Pure combinational RV32I base-ISA decoder: raw instruction word to decoded_t.
module rv32i_decode_comb
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    output decoded_t    dec
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign f3     = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic        legal;
    logic        use_rs1;
    logic        use_rs2;
    logic        use_rd;
    logic        use_imm;
    logic [31:0] imm;
    logic [7:0]  alu;
    op_class_e   cls;

    // Classify the opcode, pick the immediate format and check encoding legality
    always_comb begin
        legal   = 1'b1;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        use_imm = 1'b0;
        imm     = '0;
        alu     = ALU_NOP;
        cls     = CLS_ALU;
        case (opcode)
            OPC_OP: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
                alu     = alu_base(f3);
                if (funct7 == 7'h20) begin
                    if (f3 == 3'b000)      alu = ALU_SUB;
                    else if (f3 == 3'b101) alu = ALU_SRA;
                    else                   legal = 1'b0;
                end else if (funct7 != 7'h00) begin
                    legal = 1'b0;
                end
            end
            OPC_OPIMM: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                use_imm = 1'b1;
                imm     = imm_i;
                alu     = alu_base(f3);
                if (f3 == 3'b001 && funct7 != 7'h00) legal = 1'b0;
                if (f3 == 3'b101) begin
                    if (funct7 == 7'h20)      alu = ALU_SRA;
                    else if (funct7 != 7'h00) legal = 1'b0;
                end
            end
            OPC_LOAD: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                use_imm = 1'b1;
                imm     = imm_i;
                alu     = ALU_ADD;
                cls     = CLS_LOAD;
                legal   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                          (f3 == 3'b100) || (f3 == 3'b101);
            end
            OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_imm = 1'b1;
                imm     = imm_s;
                alu     = ALU_ADD;
                cls     = CLS_STORE;
                legal   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
            end
            OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_imm = 1'b1;
                imm     = imm_b;
                alu     = ALU_SUB;
                cls     = CLS_BRANCH;
                legal   = (f3 != 3'b010) && (f3 != 3'b011);
            end
            OPC_JAL: begin
                use_rd  = 1'b1;
                use_imm = 1'b1;
                imm     = imm_j;
                alu     = ALU_ADD;
                cls     = CLS_JAL;
            end
            OPC_JALR: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
                use_imm = 1'b1;
                imm     = imm_i;
                alu     = ALU_ADD;
                cls     = CLS_JALR;
                legal   = (f3 == 3'b000);
            end
            OPC_LUI: begin
                use_rd  = 1'b1;
                use_imm = 1'b1;
                imm     = imm_u;
                alu     = ALU_PASSB;
                cls     = CLS_LUI;
            end
            OPC_AUIPC: begin
                use_rd  = 1'b1;
                use_imm = 1'b1;
                imm     = imm_u;
                alu     = ALU_ADD;
                cls     = CLS_AUIPC;
            end
            default: legal = 1'b0;
        endcase
    end

    // Assemble the entry; unused fields are zeroed and illegal entries carry no enables
    always_comb begin
        dec        = '0;
        dec.funct3 = f3;
        if (legal) begin
            dec.rs1_addr   = use_rs1 ? rs1 : 5'd0;
            dec.rs2_addr   = use_rs2 ? rs2 : 5'd0;
            dec.w_addr     = use_rd  ? rd  : 5'd0;
            dec.imm        = use_imm ? imm : 32'd0;
            dec.aluop      = alu;
            dec.op_class   = cls;
            dec.r1_enable  = use_rs1;
            dec.r2_enable  = use_rs2;
            dec.w_enable   = use_rd & (rd != 5'd0);
            dec.imm_enable = use_imm;
        end else begin
            dec.illegal    = 1'b1;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage with valid/ready on both sides, an optional
// skid entry for full throughput under backpressure, and synchronous flush.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN    = DEC_XLEN,
    parameter int PC_W    = 32,
    parameter int ALUOP_W = DEC_ALUOP_W,
    parameter bit SKID_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    input  logic [PC_W-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [4:0]         rs1_addr,
    output logic [4:0]         rs2_addr,
    output logic [4:0]         w_addr,
    output logic [XLEN-1:0]    imm_number,
    output logic [ALUOP_W-1:0] aluop,
    output logic [2:0]         op_class,
    output logic [2:0]         funct3,
    output logic               r1_enable,
    output logic               r2_enable,
    output logic               w_enable,
    output logic               imm_enable,
    output logic               illegal
);

    decoded_t         dec_in;
    decoded_t         out_dec_q;
    decoded_t         skid_dec_q;
    logic [PC_W-1:0]  out_pc_q;
    logic [PC_W-1:0]  skid_pc_q;
    logic             out_valid_q;
    logic             skid_valid_q;
    logic             alive_q;
    logic             accept;
    logic             xfer;

    rv32i_decode_comb u_dec (
        .instr (in_instr),
        .dec   (dec_in)
    );

    // Without the skid entry, accepting while stalled is impossible, so the
    // same update rules serve both configurations; skid_valid_q then stays 0.
    assign in_ready = alive_q & (SKID_EN ? ~skid_valid_q : (out_ready | ~out_valid_q));
    assign accept   = in_valid & in_ready & ~flush;
    assign xfer     = out_valid_q & out_ready;

    // Holds in_ready low during reset and releases it on the first edge after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive_q <= 1'b0;
        else        alive_q <= 1'b1;
    end

    // Occupancy of the output and skid entries; flush wins over everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (flush) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else if (!out_valid_q || xfer) begin
            if (skid_valid_q) begin
                out_valid_q  <= 1'b1;
                skid_valid_q <= 1'b0;
            end else begin
                out_valid_q  <= accept;
            end
        end else if (accept) begin
            skid_valid_q <= 1'b1;
        end
    end

    // Entry payloads: output reloads from skid first (FIFO), else from the input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_dec_q  <= '0;
            out_pc_q   <= '0;
            skid_dec_q <= '0;
            skid_pc_q  <= '0;
        end else if (!flush) begin
            if (!out_valid_q || xfer) begin
                if (skid_valid_q) begin
                    out_dec_q <= skid_dec_q;
                    out_pc_q  <= skid_pc_q;
                end else if (accept) begin
                    out_dec_q <= dec_in;
                    out_pc_q  <= in_pc;
                end
            end else if (accept) begin
                skid_dec_q <= dec_in;
                skid_pc_q  <= in_pc;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign rs1_addr   = out_dec_q.rs1_addr;
    assign rs2_addr   = out_dec_q.rs2_addr;
    assign w_addr     = out_dec_q.w_addr;
    assign imm_number = XLEN'($signed(out_dec_q.imm));
    assign aluop      = ALUOP_W'(out_dec_q.aluop);
    assign op_class   = out_dec_q.op_class;
    assign funct3     = out_dec_q.funct3;
    assign r1_enable  = out_dec_q.r1_enable;
    assign r2_enable  = out_dec_q.r2_enable;
    assign w_enable   = out_dec_q.w_enable;
    assign imm_enable = out_dec_q.imm_enable;
    assign illegal    = out_dec_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed decodes, stall/skid stream,
// flush, asynchronous reset and a randomized run against a reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  w_addr;
    logic [31:0] imm_number;
    logic [7:0]  aluop;
    logic [2:0]  op_class;
    logic [2:0]  funct3;
    logic        r1_enable;
    logic        r2_enable;
    logic        w_enable;
    logic        imm_enable;
    logic        illegal;

    decode_stage #(.XLEN(32), .PC_W(32), .ALUOP_W(8), .SKID_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .w_addr(w_addr),
        .imm_number(imm_number), .aluop(aluop), .op_class(op_class), .funct3(funct3),
        .r1_enable(r1_enable), .r2_enable(r2_enable), .w_enable(w_enable),
        .imm_enable(imm_enable), .illegal(illegal)
    );

    always #5 clk = ~clk;

    logic [65:0] dut_fields;
    logic [97:0] dut_vec;
    assign dut_fields = {rs1_addr, rs2_addr, w_addr, imm_number, aluop, op_class, funct3,
                         r1_enable, r2_enable, w_enable, imm_enable, illegal};
    assign dut_vec    = {out_pc, dut_fields};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [7:0] alu_of_f3 [8] = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09, 8'h0a};
    logic [6:0] opcs [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};

    // Reference decode: {rs1,rs2,rd,imm,aluop,class,funct3,r1,r2,we,ie,illegal}
    function automatic logic [65:0] ref_fields(input logic [31:0] ins);
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, ra, rb;
        logic [31:0] ii, imm;
        logic [7:0]  op;
        logic [2:0]  cls;
        logic        ok, u1, u2, uw, ui;
        f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7]; ra = ins[19:15]; rb = ins[24:20];
        ii = 32'($signed(ins) >>> 20);
        ok = 1'b1; u1 = 1'b0; u2 = 1'b0; uw = 1'b0; ui = 1'b0;
        imm = '0; op = '0; cls = '0;
        case (ins[6:0])
            7'h33: begin
                u1 = 1'b1; u2 = 1'b1; uw = 1'b1;
                if (f7 == 7'h00)                     op = alu_of_f3[f3];
                else if (f7 == 7'h20 && f3 == 3'd0)  op = 8'h02;
                else if (f7 == 7'h20 && f3 == 3'd5)  op = 8'h08;
                else                                 ok = 1'b0;
            end
            7'h13: begin
                u1 = 1'b1; uw = 1'b1; ui = 1'b1; imm = ii;
                if (f3 == 3'd1) begin
                    ok = (f7 == 7'h00); op = 8'h03;
                end else if (f3 == 3'd5) begin
                    if (f7 == 7'h00)      op = 8'h07;
                    else if (f7 == 7'h20) op = 8'h08;
                    else                  ok = 1'b0;
                end else begin
                    op = alu_of_f3[f3];
                end
            end
            7'h03: begin
                u1 = 1'b1; uw = 1'b1; ui = 1'b1; imm = ii; op = 8'h01; cls = 3'd1;
                ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
            end
            7'h23: begin
                u1 = 1'b1; u2 = 1'b1; ui = 1'b1; op = 8'h01; cls = 3'd2;
                imm = (32'($signed(ins) >>> 25) << 5) | 32'(ins[11:7]);
                ok = (f3 <= 3'd2);
            end
            7'h63: begin
                u1 = 1'b1; u2 = 1'b1; ui = 1'b1; op = 8'h02; cls = 3'd3;
                imm = (ins[31] ? 32'hFFFFF000 : 32'h0) + 32'(ins[7]) * 32'd2048 +
                      32'(ins[30:25]) * 32'd32 + 32'(ins[11:8]) * 32'd2;
                ok = (f3 != 3'd2) && (f3 != 3'd3);
            end
            7'h6F: begin
                uw = 1'b1; ui = 1'b1; op = 8'h01; cls = 3'd4;
                imm = (ins[31] ? 32'hFFF00000 : 32'h0) + 32'(ins[19:12]) * 32'd4096 +
                      32'(ins[20]) * 32'd2048 + 32'(ins[30:21]) * 32'd2;
            end
            7'h67: begin
                u1 = 1'b1; uw = 1'b1; ui = 1'b1; imm = ii; op = 8'h01; cls = 3'd5;
                ok = (f3 == 3'd0);
            end
            7'h37: begin uw = 1'b1; ui = 1'b1; imm = ins & 32'hFFFFF000; op = 8'h0b; cls = 3'd6; end
            7'h17: begin uw = 1'b1; ui = 1'b1; imm = ins & 32'hFFFFF000; op = 8'h01; cls = 3'd7; end
            default: ok = 1'b0;
        endcase
        if (!ok) return {15'd0, 32'd0, 8'd0, 3'd0, f3, 5'b00001};
        return {u1 ? ra : 5'd0, u2 ? rb : 5'd0, uw ? rd : 5'd0, ui ? imm : 32'd0, op, cls, f3,
                u1, u2, uw && (rd != 5'd0), ui, 1'b0};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        if ($urandom_range(0, 7) != 0) w[6:0] = opcs[$urandom_range(0, 8)];
        case ($urandom_range(0, 3))
            0:       w[31:25] = 7'h00;
            1:       w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    // Model: FIFO of accepted entries still to be delivered; up = stage out of reset
    logic [97:0] exp_q [$];
    bit          up = 1'b0;

    task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                        input logic ordy, input logic fl, output logic acc);
        @(negedge clk);
        chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
        chk("in_ready", 128'(in_ready), 128'(up && exp_q.size() < 2));
        in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        acc = iv && in_ready && !fl;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0) begin
                if (ordy) begin
                    chk("entry", 128'(dut_vec), 128'(exp_q[0]));
                    void'(exp_q.pop_front());
                end else begin
                    chk("hold", 128'(dut_vec), 128'(exp_q[0]));
                end
            end
            if (acc) exp_q.push_back({pc, ref_fields(ins)});
        end
        up = 1'b1;
    endtask

    task automatic dir(input string tag, input logic [31:0] ins, input logic [65:0] exp);
        logic acc;
        step(1'b1, ins, 32'h1000, 1'b1, 1'b0, acc);
        chk({tag, "_acc"}, 128'(acc), 128'(1));
        @(posedge clk); #1;
        chk({tag, "_valid"}, 128'(out_valid), 128'(1));
        chk(tag, 128'(dut_fields), 128'(exp));
    endtask

    task automatic dir_ill(input string tag, input logic [31:0] ins);
        logic acc;
        step(1'b1, ins, 32'h2000, 1'b1, 1'b0, acc);
        @(posedge clk); #1;
        chk({tag, "_valid"}, 128'(out_valid), 128'(1));
        chk(tag, 128'({aluop, r1_enable, r2_enable, w_enable, imm_enable, illegal}),
            128'({8'h00, 5'b00001}));
    endtask

    task automatic async_reset();
        @(negedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 128'(out_valid), 128'(0));
        chk("arst_fields", 128'(dut_vec), 128'(0));
        chk("arst_ready", 128'(in_ready), 128'(0));
        exp_q.delete();
        up = 1'b0;
        in_valid = 1'b0; flush = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    logic [31:0] s_ins [4] = '{32'h00108093, 32'h40208133, 32'h0000A183, 32'h00312223};

    initial begin
        logic acc;
        int   k;
        int   acc_n;
        logic [31:0] pc;
        #1;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_ready", 128'(in_ready), 128'(0));
        chk("rst_fields", 128'(dut_vec), 128'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        dir("add",  32'h002081B3, {5'd1, 5'd2, 5'd3, 32'h0, 8'h01, 3'd0, 3'd0, 5'b11100});
        dir("addi", 32'h00000013, {5'd0, 5'd0, 5'd0, 32'h0, 8'h01, 3'd0, 3'd0, 5'b10010});
        dir("beq",  32'hFE208EE3, {5'd1, 5'd2, 5'd0, 32'hFFFFFFFC, 8'h02, 3'd3, 3'd0, 5'b11010});
        dir("lui",  32'hABCDE2B7, {5'd0, 5'd0, 5'd5, 32'hABCDE000, 8'h0b, 3'd6, 3'd6, 5'b00110});
        dir_ill("ill_ones", 32'hFFFFFFFF);
        dir_ill("ill_slli", 32'h40109093);
        repeat (2) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        // Four-instruction stream with out_ready low for three cycles after the first
        k = 0; acc_n = 0;
        for (int c = 0; c < 40; c++) begin
            step(k < 4, s_ins[k % 4], 32'h200 + 32'(k) * 4, !(c >= 1 && c <= 3), 1'b0, acc);
            if (acc && c >= 1 && c <= 3) acc_n++;
            if (acc) k++;
        end
        chk("stall_accepts", 128'(acc_n), 128'(1));
        chk("stream_done", 128'(k), 128'(4));

        // Flush with output and skid both occupied and a valid input present
        step(1'b1, 32'h00108093, 32'h300, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00210113, 32'h304, 1'b0, 1'b0, acc);
        step(1'b1, 32'h00318193, 32'h308, 1'b0, 1'b1, acc);
        @(posedge clk); #1;
        chk("flush_valid", 128'(out_valid), 128'(0));
        chk("flush_ready", 128'(in_ready), 128'(1));
        step(1'b1, 32'h002081B3, 32'h30C, 1'b1, 1'b0, acc);
        @(posedge clk); #1;
        chk("post_flush_valid", 128'(out_valid), 128'(1));
        chk("post_flush_pc", 128'(out_pc), 128'(32'h30C));

        // Randomized traffic with an asynchronous reset in the middle
        pc = 32'h4000;
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) async_reset();
            step($urandom_range(0, 3) != 0, rand_instr(), pc, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 40) == 0, acc);
            if (acc) pc = pc + 4;
        end
        repeat (4) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction decode stage: full base-ISA decode (R, I, load, store, branch, LUI, AUIPC, JAL, JALR) with illegal-instruction detection.
- Sits between fetch and the register-file/ALU issue stage.
- Valid/ready handshake on both sides, optional skid buffer for full throughput under backpressure, synchronous flush for branch redirect.

Parameters:
- XLEN, 32, datapath/immediate width; immediates sign-extended to XLEN.
- PC_W, 32, width of the PC carried alongside the instruction.
- ALUOP_W, 8, width of aluop field.
- SKID_EN, 1, 1 = two-entry (output reg + skid reg), in_ready registered; 0 = single output reg, in_ready = out_ready | ~out_valid.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  drop all held entries this cycle.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts instruction.
- in_instr  in  32  raw instruction word.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  issue stage consumes.
- out_pc  out  PC_W  PC of decoded entry.
- rs1_addr, rs2_addr, w_addr  out  5 each  register indices.
- imm_number  out  XLEN  sign-extended immediate.
- aluop  out  ALUOP_W  ALU operation.
- op_class  out  3  0 alu, 1 load, 2 store, 3 branch, 4 jal, 5 jalr, 6 lui, 7 auipc.
- funct3  out  3  instr[14:12], passed through for load/store size and branch condition.
- r1_enable, r2_enable, w_enable, imm_enable  out  1 each  operand/writeback enables.
- illegal  out  1  unsupported encoding.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, skid valid=0, every data output 0, in_ready=0 while in reset, 1 on the first cycle after release.
- aluop codes: 0x00 nop, 0x01 add, 0x02 sub, 0x03 sll, 0x04 slt, 0x05 sltu, 0x06 xor, 0x07 srl, 0x08 sra, 0x09 or, 0x0a and, 0x0b passB.
- R (0110011): funct7 0x00 or 0x20; 0x20 legal only with funct3 000 (sub) or 101 (sra). r1, r2, w enabled.
- I-ALU (0010011): imm I-format. slli needs funct7=0x00; srli/srai need funct7 0x00/0x20, otherwise illegal.
- load (0000011): aluop add, imm I-format; funct3 in {000,001,010,100,101}.
- store (0100011): aluop add, imm S-format, r2_enable=1, w_enable=0; funct3 in {000,001,010}.
- branch (1100011): aluop sub, imm B-format (bit0=0), r1/r2 enabled, w_enable=0; funct3 010/011 illegal.
- jal (1101111): imm J-format, w only.
- jalr (1100111): funct3 must be 000, imm I-format.
- lui (0110111): aluop passB, imm U-format (low 12 bits 0).
- auipc (0010111): aluop add, imm U-format.
- Any other opcode: illegal.
- Illegal entry: illegal=1, aluop=0, all enables 0. The entry is still passed downstream (valid) so the trap is taken in order.
- w_enable forced 0 when w_addr==0. Unused address fields output 0.
- Latency: one cycle from accepted input (in_valid & in_ready) to out_valid.
- Transfer: occurs on valid & ready. Outputs hold stable while out_valid & ~out_ready.
- SKID_EN=1: in_ready = ~skid_valid (registered).
  - Input accepted while output stalled → goes to skid reg.
  - On an output transfer, skid moves to the output reg and in_ready returns the next cycle.
  - Sustains 1 instruction/cycle with no combinational path from out_ready to in_ready.
- Ordering: always FIFO; never reorders.
- flush=1: next edge clears out_valid and skid valid; the input that cycle is discarded even if in_valid & in_ready. Flush has priority over every other event.
- Simultaneous output transfer + input accept, skid empty: output reg reloads directly from the new input.

Decomposition:
- Package decode_pkg:
  - opcode localparams (OPC_OP, OPC_OPIMM, OPC_LOAD, ...).
  - aluop codes ALU_NOP..ALU_PASSB.
  - op_class enum.
  - struct decoded_t bundling every output field except valid and pc.
- Sub-module rv32i_decode_comb: pure combinational instr → decoded_t. decode_stage owns only the handshake, skid and pipeline registers.

Test Plan:
- add x3,x1,x2 (0x002081B3), out_ready=1 → next cycle out_valid=1, aluop=0x01, rs1=1, rs2=2, w_addr=3, r1/r2/w=1, imm_enable=0, illegal=0.
- addi x0,x0,0 (0x00000013) → aluop=0x01, imm=0, w_enable=0 (rd=x0); beq x1,x2,-4 (0xFE208EE3) → op_class=3, aluop=0x02, imm=0xFFFFFFFC, w_enable=0.
- lui x5,0xABCDE (0xABCDE2B7) → aluop=0x0b, imm=0xABCDE000; 0xFFFFFFFF and slli with funct7=0x20 (0x40109093) → illegal=1, aluop=0, enables 0, out_valid=1.
- Stream 4 instructions, out_ready low for 3 cycles after the first: SKID_EN=1 → in_ready drops after exactly one extra accept, outputs stable while stalled, all 4 delivered in order with no loss or duplication.
- flush asserted with out and skid full plus in_valid=1 → next cycle out_valid=0 and in_ready=1; the next accepted instruction appears 1 cycle later.
- rst_n pulled low mid-stream, asynchronous to clk → out_valid and outputs 0 immediately; after release the first accepted instruction decodes correctly.
